smg_scan_module: RTL and testbench

- Digit-scan sequencer for the 6-digit seven-segment display.
- Sits directly upstream of smg_control_module and drives its 6-bit one-hot cur_state.
- Produces the active-low digit-enable bus (Scan_Sig), time-aligned with the one-cycle registered digit nibble downstream.
- Provides per-digit masking (e.g. leading-zero suppression) and an anti-ghosting blank window at the start of every digit slot.

---
 rtl/smg_scan_module.sv | 113 +++++++++++
 tb/tb_smg_scan_module.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/smg_scan_module.sv
// ---------------------------------------------------------------------------
// smg_scan_module
//   Digit-scan sequencer for the 6-digit seven-segment display. It sits
//   directly upstream of smg_control_module. It produces the one-hot slot
//   select (cur_state) that picks the digit nibble. It also produces the
//   active-low digit enables (Scan_Sig). Scan_Sig is registered, so it
//   changes on the same edge as the downstream registered nibble.
//
//   Each slot lasts SCAN_DIV clk cycles. The first BLANK_CYC cycles of every
//   slot keep all digits dark, which suppresses ghosting. Blank_Mask can
//   force individual digits off, for example to suppress leading zeros.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   scan_en    in   1 = scanning, 0 = display dark and sequencer parked
//   Blank_Mask in   [5:0] per-digit force-off (bit5 = leftmost tube 6)
//   cur_state  out  [5:0] one-hot slot select to smg_control_module
//   Scan_Sig   out  [5:0] active-low digit enables (bit5 = tube 6)
//   slot_tick  out  one-cycle pulse on the last cycle of every slot
// ---------------------------------------------------------------------------
module smg_scan_module #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [5:0] Blank_Mask,
  output logic [5:0] cur_state,
  output logic [5:0] Scan_Sig,
  output logic       slot_tick
);

  localparam int unsigned CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam int          BLANK_I  = int'(BLANK_CYC);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    ST1  = 6'b000010,
    ST2  = 6'b000100,
    ST3  = 6'b001000,
    ST4  = 6'b010000,
    ST5  = 6'b100000
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          wrap;
  logic          tick_d;
  logic          blank;
  logic [5:0]    digit_sel;
  logic [5:0]    scan_d;

  // Next-state / next-output logic
  always_comb begin
    wrap      = (cnt == CNT_LAST);
    cnt_d     = '0;
    state_d   = IDLE;
    tick_d    = 1'b0;
    digit_sel = '0;
    blank     = 1'b1;
    scan_d    = '1;

    // A disabled scanner parks at IDLE, and this also wins over a
    // simultaneous slot wrap.
    if (scan_en) begin
      cnt_d = wrap ? '0 : cnt + CW'(1);
      case (state_q)
        IDLE, ST1, ST2, ST3, ST4, ST5:
          state_d = wrap ? state_t'({state_q[4:0], state_q[5]}) : state_q;
        default:
          state_d = IDLE;
      endcase
    end

    // The tick is registered, so it is set one cycle early. It is then high
    // exactly while cnt holds its last value.
    tick_d = scan_en && (cnt_d == CNT_LAST);

    // Slot to tube mapping: the tube order is the reverse of the slot order.
    case (state_q)
      IDLE:    digit_sel = 6'b100000;
      ST1:     digit_sel = 6'b010000;
      ST2:     digit_sel = 6'b001000;
      ST3:     digit_sel = 6'b000100;
      ST4:     digit_sel = 6'b000010;
      ST5:     digit_sel = 6'b000001;
      default: digit_sel = 6'b000000;
    endcase

    blank = !scan_en || (int'(cnt) < BLANK_I) || ((digit_sel & Blank_Mask) != 6'b000000);
    scan_d = blank ? '1 : ~digit_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      state_q   <= IDLE;
      Scan_Sig  <= '1;
      slot_tick <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      state_q   <= state_d;
      Scan_Sig  <= scan_d;
      slot_tick <= tick_d;
    end
  end

  assign cur_state = state_q;

endmodule

// File: tb/tb_smg_scan_module.sv
module tb_smg_scan_module;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: SCAN_DIV=8, BLANK_CYC=2
  logic       rst_n, scan_en;
  logic [5:0] Blank_Mask, cur_state, Scan_Sig;
  logic       slot_tick;

  // Second instance: SCAN_DIV=4, BLANK_CYC=0
  logic       rst4_n, scan_en4;
  logic [5:0] Blank_Mask4, cur_state4, Scan_Sig4;
  logic       slot_tick4;

  int checks = 0;
  int errors = 0;

  smg_scan_module #(.SCAN_DIV(8), .BLANK_CYC(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .Blank_Mask(Blank_Mask),
    .cur_state(cur_state), .Scan_Sig(Scan_Sig), .slot_tick(slot_tick)
  );

  smg_scan_module #(.SCAN_DIV(4), .BLANK_CYC(0)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .scan_en(scan_en4), .Blank_Mask(Blank_Mask4),
    .cur_state(cur_state4), .Scan_Sig(Scan_Sig4), .slot_tick(slot_tick4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset the main instance; on return we are 1 time unit after an edge,
  // with reset just released: "cycle 0".
  task automatic restart8(input logic [5:0] mask);
    rst_n      = 1'b0;
    scan_en    = 1'b1;
    Blank_Mask = mask;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Hand table of the first slot after a fresh start (SCAN_DIV=8, BLANK_CYC=2)
  function automatic logic [5:0] s1_scan(input int c);
    if (c < 3)       return 6'b111111;
    else if (c < 9)  return 6'b011111;
    else if (c < 11) return 6'b111111;
    else             return 6'b101111;
  endfunction

  function automatic logic [5:0] s1_state(input int c);
    return (c < 8) ? 6'b000001 : 6'b000010;
  endfunction

  function automatic logic s1_tick(input int c);
    return (c == 7) || (c == 15);
  endfunction

  // Expected Scan_Sig for the 8/2 instance, at cycle c after a fresh start
  function automatic logic [5:0] exp8(input int c, input logic [5:0] mask);
    logic [5:0] dig;
    logic [5:0] left;
    int s, p;
    if (c == 0) return 6'b111111;
    s    = ((c - 1) / 8) % 6;
    p    = (c - 1) % 8;
    left = 6'b100000;
    dig  = left >> s;
    if (p < 2 || (dig & mask) != 6'b000000) return 6'b111111;
    return ~dig;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b1; Blank_Mask = 6'b000000;
    rst4_n = 1'b0; scan_en4 = 1'b1; Blank_Mask4 = 6'b000000;
    step();
    step();
    checks++; if (cur_state !== 6'b000001) begin errors++; $display("FAIL reset_state got %b want 000001", cur_state); end
    checks++; if (Scan_Sig !== 6'b111111) begin errors++; $display("FAIL reset_scan got %b want 111111", Scan_Sig); end
    checks++; if (slot_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", slot_tick); end
    checks++; if (cur_state4 !== 6'b000001) begin errors++; $display("FAIL reset_state4 got %b want 000001", cur_state4); end
    checks++; if (Scan_Sig4 !== 6'b111111) begin errors++; $display("FAIL reset_scan4 got %b want 111111", Scan_Sig4); end
    checks++; if (slot_tick4 !== 1'b0) begin errors++; $display("FAIL reset_tick4 got %b want 0", slot_tick4); end
  endtask

  task automatic test_first_slot();
    restart8(6'b000000);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      checks++; if (cur_state !== s1_state(c)) begin errors++; $display("FAIL s1_state c=%0d got %b want %b", c, cur_state, s1_state(c)); end
      checks++; if (Scan_Sig !== s1_scan(c)) begin errors++; $display("FAIL s1_scan c=%0d got %b want %b", c, Scan_Sig, s1_scan(c)); end
      checks++; if (slot_tick !== s1_tick(c)) begin errors++; $display("FAIL s1_tick c=%0d got %b want %b", c, slot_tick, s1_tick(c)); end
    end
  endtask

  task automatic test_full_frame();
    int ticks = 0;
    int seq_err = 0;
    int multi = 0;
    int low [6];
    logic [5:0] one;
    logic [5:0] want;
    one = 6'b000001;
    for (int b = 0; b < 6; b++) low[b] = 0;
    restart8(6'b000000);
    for (int c = 0; c <= 48; c++) begin
      if (c > 0) step();
      want = one << ((c / 8) % 6);
      if (cur_state !== want) seq_err++;
      if (c < 48 && slot_tick === 1'b1) ticks++;
      if (c >= 1) begin
        for (int b = 0; b < 6; b++) if (Scan_Sig[b] === 1'b0) low[b]++;
        if ($countones(~Scan_Sig) > 1) multi++;
      end
    end
    checks++; if (seq_err !== 0) begin errors++; $display("FAIL frame_seq bad_cycles=%0d want 0", seq_err); end
    checks++; if (cur_state !== 6'b000001) begin errors++; $display("FAIL frame_return got %b want 000001", cur_state); end
    checks++; if (ticks !== 6) begin errors++; $display("FAIL frame_ticks got %0d want 6", ticks); end
    checks++; if (multi !== 0) begin errors++; $display("FAIL frame_multi_low got %0d want 0", multi); end
    for (int b = 0; b < 6; b++) begin
      checks++; if (low[b] !== 6) begin errors++; $display("FAIL frame_low bit%0d got %0d want 6", b, low[b]); end
    end
  endtask

  task automatic test_mask();
    restart8(6'b100000);
    for (int c = 0; c <= 52; c++) begin
      if (c > 0) step();
      checks++; if (Scan_Sig !== exp8(c, 6'b100000)) begin errors++; $display("FAIL mask_scan c=%0d got %b want %b", c, Scan_Sig, exp8(c, 6'b100000)); end
    end
    // c=52 is mid-IDLE past the blank window; clear the mask
    Blank_Mask = 6'b000000;
    step();
    checks++; if (Scan_Sig !== 6'b011111) begin errors++; $display("FAIL mask_clear got %b want 011111", Scan_Sig); end
    step();
    checks++; if (Scan_Sig !== 6'b011111) begin errors++; $display("FAIL mask_clear_hold got %b want 011111", Scan_Sig); end
  endtask

  task automatic test_disable();
    restart8(6'b000000);
    for (int c = 1; c <= 28; c++) step();
    checks++; if (cur_state !== 6'b001000) begin errors++; $display("FAIL dis_pre_state got %b want 001000", cur_state); end
    checks++; if (Scan_Sig !== 6'b111011) begin errors++; $display("FAIL dis_pre_scan got %b want 111011", Scan_Sig); end
    scan_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (cur_state !== 6'b000001) begin errors++; $display("FAIL dis_state k=%0d got %b want 000001", k, cur_state); end
      checks++; if (Scan_Sig !== 6'b111111) begin errors++; $display("FAIL dis_scan k=%0d got %b want 111111", k, Scan_Sig); end
      checks++; if (slot_tick !== 1'b0) begin errors++; $display("FAIL dis_tick k=%0d got %b want 0", k, slot_tick); end
    end
    scan_en = 1'b1;
    for (int d = 0; d <= 12; d++) begin
      if (d > 0) step();
      checks++; if (cur_state !== s1_state(d)) begin errors++; $display("FAIL reen_state d=%0d got %b want %b", d, cur_state, s1_state(d)); end
      checks++; if (Scan_Sig !== s1_scan(d)) begin errors++; $display("FAIL reen_scan d=%0d got %b want %b", d, Scan_Sig, s1_scan(d)); end
      checks++; if (slot_tick !== s1_tick(d)) begin errors++; $display("FAIL reen_tick d=%0d got %b want %b", d, slot_tick, s1_tick(d)); end
    end
  endtask

  task automatic test_disable_at_wrap();
    restart8(6'b000000);
    for (int c = 1; c <= 7; c++) step();
    checks++; if (slot_tick !== 1'b1) begin errors++; $display("FAIL wrap_pre_tick got %b want 1", slot_tick); end
    scan_en = 1'b0;
    step();
    checks++; if (cur_state !== 6'b000001) begin errors++; $display("FAIL wrap_dis_state got %b want 000001", cur_state); end
    checks++; if (Scan_Sig !== 6'b111111) begin errors++; $display("FAIL wrap_dis_scan got %b want 111111", Scan_Sig); end
    checks++; if (slot_tick !== 1'b0) begin errors++; $display("FAIL wrap_dis_tick got %b want 0", slot_tick); end
    scan_en = 1'b1;
  endtask

  task automatic test_async_reset();
    restart8(6'b000000);
    for (int c = 1; c <= 39; c++) step();
    checks++; if (cur_state !== 6'b010000) begin errors++; $display("FAIL ares_pre_state got %b want 010000", cur_state); end
    checks++; if (Scan_Sig !== 6'b111101) begin errors++; $display("FAIL ares_pre_scan got %b want 111101", Scan_Sig); end
    checks++; if (slot_tick !== 1'b1) begin errors++; $display("FAIL ares_pre_tick got %b want 1", slot_tick); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (cur_state !== 6'b000001) begin errors++; $display("FAIL ares_state got %b want 000001", cur_state); end
    checks++; if (Scan_Sig !== 6'b111111) begin errors++; $display("FAIL ares_scan got %b want 111111", Scan_Sig); end
    checks++; if (slot_tick !== 1'b0) begin errors++; $display("FAIL ares_tick got %b want 0", slot_tick); end
    step();
    rst_n = 1'b1;
    for (int d = 0; d <= 12; d++) begin
      if (d > 0) step();
      checks++; if (cur_state !== s1_state(d)) begin errors++; $display("FAIL ares_rel_state d=%0d got %b want %b", d, cur_state, s1_state(d)); end
      checks++; if (Scan_Sig !== s1_scan(d)) begin errors++; $display("FAIL ares_rel_scan d=%0d got %b want %b", d, Scan_Sig, s1_scan(d)); end
      checks++; if (slot_tick !== s1_tick(d)) begin errors++; $display("FAIL ares_rel_tick d=%0d got %b want %b", d, slot_tick, s1_tick(d)); end
    end
  endtask

  task automatic test_no_blank();
    logic [5:0] one;
    logic [5:0] left;
    logic [5:0] ws;
    logic [5:0] wsc;
    logic       wt;
    one  = 6'b000001;
    left = 6'b100000;
    rst4_n = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) step();
      ws  = one << ((c / 4) % 6);
      wsc = (c == 0) ? 6'b111111 : ~(left >> (((c - 1) / 4) % 6));
      wt  = ((c % 4) == 3);
      checks++; if (cur_state4 !== ws) begin errors++; $display("FAIL nb_state c=%0d got %b want %b", c, cur_state4, ws); end
      checks++; if (Scan_Sig4 !== wsc) begin errors++; $display("FAIL nb_scan c=%0d got %b want %b", c, Scan_Sig4, wsc); end
      checks++; if (slot_tick4 !== wt) begin errors++; $display("FAIL nb_tick c=%0d got %b want %b", c, slot_tick4, wt); end
    end
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_full_frame();
    test_mask();
    test_disable();
    test_disable_at_wrap();
    test_async_reset();
    test_no_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
